// File: rtl/ex_result_flag_stage.sv
// EX/MEM boundary register with the architectural Z/V/N flags, a same-cycle
// flag bypass for branch resolution, and a sticky halt.
module ex_result_flag_stage #(
    parameter int DATA_WIDTH = 16,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  EX_Valid,
    input  logic [3:0]            EX_Opcode,
    input  logic [DATA_WIDTH-1:0] EX_Result,
    input  logic                  EX_Ovfl,
    input  logic [REG_ADDR_W-1:0] EX_DstReg,
    input  logic                  EX_RegWrite,
    input  logic                  Stall,
    input  logic                  Flush,
    output logic                  MEM_Valid,
    output logic [DATA_WIDTH-1:0] MEM_Result,
    output logic [REG_ADDR_W-1:0] MEM_DstReg,
    output logic                  MEM_RegWrite,
    output logic                  Flag_Z,
    output logic                  Flag_V,
    output logic                  Flag_N,
    output logic                  Byp_Z,
    output logic                  Byp_V,
    output logic                  Byp_N,
    output logic                  Halted
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    logic commit;
    logic wr_zvn;
    logic wr_z;
    logic new_z;
    logic new_v;
    logic new_n;

    assign commit = EX_Valid & ~Stall & ~Flush & ~Halted;

    always_comb begin
        wr_zvn = 1'b0;
        wr_z   = 1'b0;
        case (EX_Opcode)
            OP_ADD, OP_SUB: begin
                wr_zvn = 1'b1;
                wr_z   = 1'b1;
            end
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: wr_z = 1'b1;
            default: ;
        endcase
    end

    assign new_z = (EX_Result == '0);
    assign new_v = EX_Ovfl;
    assign new_n = EX_Result[DATA_WIDTH-1];

    // Bypass shows the flags as they will be after this EX instruction commits.
    assign Byp_Z = (commit & wr_z)   ? new_z : Flag_Z;
    assign Byp_V = (commit & wr_zvn) ? new_v : Flag_V;
    assign Byp_N = (commit & wr_zvn) ? new_n : Flag_N;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            MEM_Valid    <= 1'b0;
            MEM_Result   <= '0;
            MEM_DstReg   <= '0;
            MEM_RegWrite <= 1'b0;
            Flag_Z       <= 1'b0;
            Flag_V       <= 1'b0;
            Flag_N       <= 1'b0;
            Halted       <= 1'b0;
        end else if (Halted) begin
            // frozen until reset
        end else if (Flush) begin
            MEM_Valid    <= 1'b0;
            MEM_Result   <= '0;
            MEM_DstReg   <= '0;
            MEM_RegWrite <= 1'b0;
        end else if (!Stall) begin
            MEM_Valid    <= EX_Valid;
            MEM_Result   <= EX_Result;
            MEM_DstReg   <= EX_DstReg;
            MEM_RegWrite <= EX_Valid & EX_RegWrite;
            if (commit && wr_z)   Flag_Z <= new_z;
            if (commit && wr_zvn) begin
                Flag_V <= new_v;
                Flag_N <= new_n;
            end
            if (commit && EX_Opcode == OP_HLT) Halted <= 1'b1;
        end
    end

endmodule

// File: doc/ex_result_flag_stage.md
Name: ex_result_flag_stage

Overview:
EX/MEM boundary stage that sits directly downstream of the EX-stage shifter/ALU result mux. It registers the 16-bit execute result with its destination and control bits for the MEM stage. It also owns the architectural Z/V/N flag register, updated per opcode class. It provides a same-cycle flag bypass for branch resolution, and a sticky halt indication.

Parameters:
DATA_WIDTH, 16, width of the result path (flags defined on bit DATA_WIDTH-1).
REG_ADDR_W, 4, width of the destination register index.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
EX_Valid  input  1  EX slot holds a real instruction.
EX_Opcode  input  4  opcode of the EX instruction.
EX_Result  input  DATA_WIDTH  shifter/ALU result selected in EX.
EX_Ovfl  input  1  signed overflow from ADD/SUB.
EX_DstReg  input  REG_ADDR_W  destination register.
EX_RegWrite  input  1  EX instruction writes the register file.
Stall  input  1  hold stage contents.
Flush  input  1  squash the EX instruction.
MEM_Valid  output  1  registered EX_Valid.
MEM_Result  output  DATA_WIDTH  registered EX_Result.
MEM_DstReg  output  REG_ADDR_W  registered EX_DstReg.
MEM_RegWrite  output  1  registered EX_RegWrite, gated by valid.
Flag_Z, Flag_V, Flag_N  output  1 each  architectural flags (registered).
Byp_Z, Byp_V, Byp_N  output  1 each  flags as they will be after the current EX instruction (combinational).
Halted  output  1  sticky: HLT has reached MEM.

Behaviour:
- Reset (async, rst=1): all outputs registered to 0; Halted=0; Byp_* then equal the zeroed flags unless the EX slot updates them.
- Opcode classes:
  - ADD 0000 / SUB 0001: update Z, V, N.
  - XOR 0010, SLL 0100, SRA 0101, ROR 0110: update Z only; V, N hold.
  - All other opcodes: no flag update.
  - HLT 1111 is the halt opcode.
- Flag values:
  - Z = (EX_Result == 0).
  - N = EX_Result[DATA_WIDTH-1].
  - V = EX_Ovfl.
- Commit condition: commit = EX_Valid & ~Stall & ~Flush & ~Halted.
- Priority at each rising edge, highest first: rst, Halted, Flush, Stall, normal.
  - Halted=1: all registers freeze until reset. Stall and Flush are ignored.
  - Flush=1:
    - MEM_Valid<=0 and MEM_RegWrite<=0.
    - MEM_Result and MEM_DstReg <= 0.
    - Flags unchanged.
    - Flush wins over a simultaneous Stall.
  - Stall=1 (no Flush): every register holds, including the flags.
  - Normal:
    - MEM_Valid<=EX_Valid.
    - MEM_RegWrite<=EX_Valid&EX_RegWrite.
    - MEM_Result<=EX_Result and MEM_DstReg<=EX_DstReg, unconditionally.
    - Flags update per the class rules only when commit=1.
    - Halted<=1 if commit and EX_Opcode==1111.
- Latency: 1 cycle from EX inputs to MEM_* and Flag_*.
- Bypass:
  - Byp_x = the new value if commit=1 and the opcode class writes flag x; otherwise Flag_x.
  - Zero-latency path; no combinational loop from Stall/Flush back into EX inputs.
- An invalid EX slot (EX_Valid=0) never changes flags or Halted, whatever its opcode.
- Back-to-back flag writers: each committed instruction's flags are visible on Flag_* the cycle after it commits, and on Byp_* during its own EX cycle.
- Reset asserted mid-stall or mid-flush clears everything immediately, without waiting for a clock edge.

Test Plan:
1. Reset then ADD: EX_Opcode=0000, EX_Result=0x0000, EX_Ovfl=1, valid.
   - Same cycle: Byp_Z=1, Byp_V=1, Byp_N=0.
   - Next edge: Flag_Z=1, Flag_V=1, Flag_N=0, MEM_Result=0x0000, MEM_Valid=1.
2. SRA after ADD: after scenario 1, issue SRA with EX_Result=0x8000, EX_Ovfl=1.
   - Required: Flag_Z=0, Flag_V=1 (held), Flag_N=0 (held).
   - Bypass: Byp_N stays 0 during the SRA cycle.
3. Stall hold: SUB with result 0xFFFF, Stall=1 for 3 cycles.
   - During stall: MEM_*, Flag_* unchanged from prior values; Byp_* equal Flag_*.
   - First edge after Stall drops: Flag_N=1, Flag_Z=0.
4. Flush with stall and RegWrite: Flush=1 and Stall=1 together on an ADD with EX_RegWrite=1, result 0x0000.
   - Next edge: MEM_Valid=0, MEM_RegWrite=0, MEM_Result=0.
   - Flags unchanged (Flag_Z not set).
5. Halt freeze: valid HLT, then ADD with result 0x0000.
   - Halted=1 after the HLT edge.
   - The following ADD leaves the flags and MEM_* frozen; Byp_* equal Flag_*.
   - rst pulse clears Halted asynchronously.
6. Invalid slot: EX_Valid=0 with EX_Opcode=0000 and EX_Result=0 -> flags unchanged, MEM_Valid=0, MEM_RegWrite=0.
